// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand/result bundle for the bit-serial subtractor.
//   iStart  - start request          iData_a - minuend      iData_b - subtrahend
//   iB      - borrow-in              oData   - difference   oData_B - borrow-out
//   oBusy   - subtraction running    oDone   - one-cycle result-valid pulse
//   oOverflow (only with SERIAL_SUB_OVERFLOW_EN) - signed overflow of A - B - iB
// master: requester side (drives the i* signals); slave: the subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             iB;
    logic [WIDTH-1:0] oData;
    logic             oData_B;
    logic             oBusy;
    logic             oDone;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             oOverflow;
    modport master (output iStart, iData_a, iData_b, iB, input oData, oData_B, oBusy, oDone, oOverflow);
    modport slave  (input iStart, iData_a, iData_b, iB, output oData, oData_B, oBusy, oDone, oOverflow);
`else
    modport master (output iStart, iData_a, iData_b, iB, input oData, oData_B, oBusy, oDone);
    modport slave  (input iStart, iData_a, iData_b, iB, output oData, oData_B, oBusy, oDone);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - iB, LSB first, one full-subtractor cell plus a borrow flip-flop.
//   iClk   - clock, rising edge
//   iRst_n - asynchronous active-low reset
//   bus    - serial_subtractor_if.slave (start, operands, borrow-in, result, borrow-out, busy, done)
// Optional macro SERIAL_SUB_OVERFLOW_EN adds bus.oOverflow (signed overflow, registered with oData).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                iClk,
    input logic                iRst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_data;
    logic             r_data_b;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_br;
    logic             w_last;
    logic             w_accept;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             r_ovf;
`endif

    assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br   = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    assign w_last = r_cnt == CW'(WIDTH - 1);
    // A start still pending in DONE is taken on the edge leaving DONE, giving WIDTH+1 cycle throughput.
    assign w_accept = (r_state == IDLE || r_state == DONE) && bus.iStart;

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = RUN;
        else if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_data   <= '0;
            r_data_b <= 1'b0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= bus.iData_a;
            r_b   <= bus.iData_b;
            r_br  <= bus.iB;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_data   <= {w_d, r_res[WIDTH-1:1]};
                r_data_b <= w_br;
`ifdef SERIAL_SUB_OVERFLOW_EN
                // On the last bit r_a[0]/r_b[0] hold the operand sign bits and w_d is the result sign.
                r_ovf    <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
`endif
            end
        end
    end

    assign bus.oData   = r_data;
    assign bus.oData_B = r_data_b;
    assign bus.oBusy   = r_state == RUN;
    assign bus.oDone   = r_state == DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.oOverflow = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 iClk = ~iClk;

    serial_subtractor_if #(.WIDTH(8)) bus();
    serial_subtractor #(.WIDTH(8)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge iClk);
        bus.iData_a = a;
        bus.iData_b = b;
        bus.iB      = bi;
        bus.iStart  = 1'b1;
        @(negedge iClk);
        bus.iStart  = 1'b0;
    endtask

    // Steps negedges until oDone, bounded; lat returns the number of steps taken.
    task automatic wait_done(output int lat, output int busy);
        lat = 0;
        busy = 0;
        while (bus.oDone !== 1'b1 && lat < 20) begin
            if (bus.oBusy === 1'b1) busy++;
            @(negedge iClk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (bus.oData !== 8'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL reset_borrow: got %b want 0", bus.oData_B); end
        n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
        n_cmp++; if (bus.oDone !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.oDone); end
`ifdef SERIAL_SUB_OVERFLOW_EN
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.oOverflow); end
`endif
        @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, busy;
        start_op(8'd100, 8'd37, 1'b0);
        wait_done(lat, busy);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_cmp++; if (busy !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", busy); end
        n_cmp++; if (bus.oData !== 8'd63) begin n_bad++; $display("FAIL basic_data: got %0d want 63", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL basic_borrow: got %b want 0", bus.oData_B); end
        n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_done: got %b want 0", bus.oBusy); end
        repeat (3) @(negedge iClk);
        n_cmp++; if (bus.oDone !== 1'b0) begin n_bad++; $display("FAIL done_single_pulse: got %b want 0", bus.oDone); end
        n_cmp++; if (bus.oData !== 8'd63) begin n_bad++; $display("FAIL hold_idle: got %0d want 63", bus.oData); end
    endtask

    task automatic test_borrow;
        int lat, busy;
        start_op(8'd5, 8'd10, 1'b0);
        n_cmp++; if (bus.oData !== 8'd63) begin n_bad++; $display("FAIL hold_run: got %0d want 63", bus.oData); end
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'hFB) begin n_bad++; $display("FAIL borrow_data: got %0h want fb", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b1) begin n_bad++; $display("FAIL borrow_out: got %b want 1", bus.oData_B); end
        start_op(8'd0, 8'd0, 1'b1);
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL bin_data: got %0h want ff", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b1) begin n_bad++; $display("FAIL bin_borrow: got %b want 1", bus.oData_B); end
        start_op(8'hFF, 8'hFF, 1'b0);
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL ff_data: got %0h want 0", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL ff_borrow: got %b want 0", bus.oData_B); end
    endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
    task automatic test_overflow;
        int lat, busy;
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'h7F) begin n_bad++; $display("FAIL ovf1_data: got %0h want 7f", bus.oData); end
        n_cmp++; if (bus.oOverflow !== 1'b1) begin n_bad++; $display("FAIL ovf1_flag: got %b want 1", bus.oOverflow); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL ovf1_borrow: got %b want 0", bus.oData_B); end
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'h0F) begin n_bad++; $display("FAIL ovf0_data: got %0h want 0f", bus.oData); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_bad++; $display("FAIL ovf0_flag: got %b want 0", bus.oOverflow); end
    endtask
`endif

    task automatic test_ignore_start;
        int lat, busy;
        start_op(8'd50, 8'd20, 1'b0);
        repeat (2) @(negedge iClk);
        bus.iData_a = 8'd1;
        bus.iData_b = 8'd2;
        bus.iStart  = 1'b1;
        @(negedge iClk);
        bus.iStart  = 1'b0;
        wait_done(lat, busy);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end
        n_cmp++; if (bus.oData !== 8'd30) begin n_bad++; $display("FAIL ignore_data: got %0d want 30", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL ignore_borrow: got %b want 0", bus.oData_B); end
        @(negedge iClk);
        n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: got busy %b want 0", bus.oBusy); end
    endtask

    task automatic test_back_to_back;
        int lat, busy;
        @(negedge iClk);
        bus.iData_a = 8'd9;
        bus.iData_b = 8'd4;
        bus.iB      = 1'b0;
        bus.iStart  = 1'b1;
        @(negedge iClk);
        wait_done(lat, busy);
        n_cmp++; if (bus.oData !== 8'd5) begin n_bad++; $display("FAIL b2b_first_data: got %0d want 5", bus.oData); end
        bus.iData_a = 8'd7;
        bus.iData_b = 8'd9;
        bus.iB      = 1'b1;
        @(negedge iClk);
        bus.iStart  = 1'b0;
        n_cmp++; if (bus.oBusy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_leaving_done: got busy %b want 1", bus.oBusy); end
        n_cmp++; if (bus.oData !== 8'd5) begin n_bad++; $display("FAIL b2b_hold: got %0d want 5", bus.oData); end
        wait_done(lat, busy);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL b2b_latency: got %0d want 8", lat); end
        n_cmp++; if (bus.oData !== 8'd253) begin n_bad++; $display("FAIL b2b_second_data: got %0d want 253", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b1) begin n_bad++; $display("FAIL b2b_second_borrow: got %b want 1", bus.oData_B); end
    endtask

    task automatic test_async_reset;
        int lat, busy;
        logic seen;
        start_op(8'd100, 8'd1, 1'b0);
        repeat (2) @(negedge iClk);
        #2 iRst_n = 1'b0;
        #1;
        n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.oBusy); end
        n_cmp++; if (bus.oData !== 8'd0) begin n_bad++; $display("FAIL arst_data: got %0d want 0", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL arst_borrow: got %b want 0", bus.oData_B); end
        n_cmp++; if (bus.oDone !== 1'b0) begin n_bad++; $display("FAIL arst_done: got %b want 0", bus.oDone); end
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge iClk);
            seen = seen | bus.oDone | bus.oBusy;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL arst_no_done: got activity %b want 0", seen); end
        start_op(8'd200, 8'd55, 1'b0);
        wait_done(lat, busy);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 8", lat); end
        n_cmp++; if (bus.oData !== 8'd145) begin n_bad++; $display("FAIL post_rst_data: got %0d want 145", bus.oData); end
        n_cmp++; if (bus.oData_B !== 1'b0) begin n_bad++; $display("FAIL post_rst_borrow: got %b want 0", bus.oData_B); end
    endtask

    initial begin
        bus.iStart  = 1'b0;
        bus.iData_a = 8'd0;
        bus.iData_b = 8'd0;
        bus.iB      = 1'b0;
        test_reset;
        test_basic;
        test_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
        test_overflow;
`endif
        test_ignore_start;
        test_back_to_back;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
